// File: rtl/serial_sub_ctrl_pkg.sv
// Shared FSM encodings and default width for the bit-serial subtractor.
// Optional compare flags are enabled by defining SERIAL_SUB_CMP_EN.
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of serial_sub_ctrl.
// Compare flags lt/eq/gt exist only when SERIAL_SUB_CMP_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = serial_sub_ctrl_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

`ifdef SERIAL_SUB_CMP_EN
  logic lt;
  logic eq;
  logic gt;

  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out, lt, eq, gt);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out, lt, eq, gt);
`else
  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out);
`endif

endinterface

// File: rtl/serial_sub_ctrl_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: one full-subtractor cell stepped LSB first.
// Define SERIAL_SUB_CMP_EN to add registered lt/eq/gt compare flags.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d, cell_bout;

`ifdef SERIAL_SUB_CMP_EN
  logic lt_q, lt_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;
`endif

  full_sub_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_CMP_EN
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          diff_d   = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so bit 0 ends at position 0 after WIDTH shifts.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = {cell_d, diff_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_CMP_EN
          lt_d    = cell_bout;
          eq_d    = !cell_bout && (diff_d == '0);
          gt_d    = !lt_d && !eq_d;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_CMP_EN
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_CMP_EN
  assign bus.lt         = lt_q;
  assign bus.eq         = eq_q;
  assign bus.gt         = gt_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized and directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Compare-flag checks are active only when SERIAL_SUB_CMP_EN is defined.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modular arithmetic and unsigned comparison.
  function automatic int ref_diff(input int x, input int y);
    return (x - y + MOD) % MOD;
  endfunction

  task automatic launch(input int x, input int y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = WIDTH'(x);
    bus.b     = WIDTH'(y);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.borrow_out} !== 3'b000 || bus.diff !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs busy=%b done=%b diff=%h borrow=%b required all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out);
    end
`ifdef SERIAL_SUB_CMP_EN
    vectors++;
    if ({bus.lt, bus.eq, bus.gt} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags lt/eq/gt=%b%b%b required 000", bus.lt, bus.eq, bus.gt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input int x, input int y);
    int cycles;
    bit timed_out;
    int exp_d;
    launch(x, y);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_busy busy=%b required 1", name, bus.busy);
    end
    wait_done(cycles, timed_out);
    exp_d = ref_diff(x, y);
    vectors++;
    if (timed_out || cycles != WIDTH) begin
      miscompares++;
      $display("[TB] FAIL %s_latency cycles=%0d timeout=%b required %0d", name, cycles, timed_out, WIDTH);
    end
    vectors++;
    if (bus.diff !== WIDTH'(exp_d) || bus.borrow_out !== (x < y)) begin
      miscompares++;
      $display("[TB] FAIL %s_result a=%0d b=%0d diff=%h borrow=%b required diff=%h borrow=%b",
               name, x, y, bus.diff, bus.borrow_out, WIDTH'(exp_d), (x < y));
    end
`ifdef SERIAL_SUB_CMP_EN
    vectors++;
    if ({bus.lt, bus.eq, bus.gt} !== {(x < y), (x == y), (x > y)}) begin
      miscompares++;
      $display("[TB] FAIL %s_flags lt/eq/gt=%b%b%b required %b%b%b", name,
               bus.lt, bus.eq, bus.gt, (x < y), (x == y), (x > y));
    end
`endif
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== WIDTH'(exp_d)) begin
      miscompares++;
      $display("[TB] FAIL %s_after_done done=%b busy=%b diff=%h required done=0 busy=0 diff=%h",
               name, bus.done, bus.busy, bus.diff, WIDTH'(exp_d));
    end
  endtask

  task automatic test_directed();
    run_and_check("d200_55", 200, 55);
    run_and_check("d5_9", 5, 9);
    run_and_check("d5a_5a", 8'h5A, 8'h5A);
    run_and_check("d0_1", 0, 1);
    run_and_check("d255_0", 255, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_and_check("rand", int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
    end
  endtask

  // With start held high, an acceptance happens every WIDTH+2 cycles starting from idle.
  task automatic test_start_held();
    int ops_a[40];
    int ops_b[40];
    int exp_d;
    bit exp_done;
    for (int m = 0; m < 40; m++) begin
      ops_a[m]  = int'($urandom_range(0, MOD - 1));
      ops_b[m]  = int'($urandom_range(0, MOD - 1));
      bus.start = 1'b1;
      bus.a     = WIDTH'(ops_a[m]);
      bus.b     = WIDTH'(ops_b[m]);
      @(negedge clk);
      exp_done = (m >= WIDTH) && ((m - WIDTH) % (WIDTH + 2) == 0);
      vectors++;
      if (bus.done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL held_done cycle=%0d done=%b required %b", m, bus.done, exp_done);
      end
      if (exp_done) begin
        exp_d = ref_diff(ops_a[m - WIDTH], ops_b[m - WIDTH]);
        vectors++;
        if (bus.diff !== WIDTH'(exp_d) || bus.borrow_out !== (ops_a[m - WIDTH] < ops_b[m - WIDTH])) begin
          miscompares++;
          $display("[TB] FAIL held_result cycle=%0d diff=%h borrow=%b required diff=%h borrow=%b",
                   m, bus.diff, bus.borrow_out, WIDTH'(exp_d), (ops_a[m - WIDTH] < ops_b[m - WIDTH]));
        end
      end
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_idle busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    launch(200, 55);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.borrow_out} !== 3'b000 || bus.diff !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs busy=%b done=%b diff=%h borrow=%b required all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done activity=%b required 0", saw_done);
    end
    run_and_check("post_reset", 10, 3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
